wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter N, default 32: data width of every write-back data port.
REQ-002 Parameter DEPTH, default 2: load-result buffer entries (legal range 2..4).
REQ-003 Parameter AGE_MAX, default 4: cycles a buffered load may wait before a forced drain.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 core_wb_valid  input  1  single-cycle pipeline requests a register-file write this cycle.
REQ-007 core_wb_rd  input  5  destination register of the core write.
REQ-008 core_wb_data  input  N  core write-back data (selected ALU/mem/U-type result).
REQ-009 core_stall  output  1  core must hold its current instruction (combinational).
REQ-010 ld_valid  input  1  long-latency load unit presents a result.
REQ-011 ld_ready  output  1  arbiter accepts the load result this cycle.
REQ-012 ld_rd  input  5  destination register of the load result.
REQ-013 ld_data  input  N  load result data.
REQ-014 rf_we  output  1  registered register-file write enable.
REQ-015 rf_waddr  output  5  registered register-file write address.
REQ-016 rf_wdata  output  N  registered register-file write data.
REQ-017 buf_count  output  $clog2(DEPTH+1)  number of occupied buffer entries.

Function
REQ-018 One register-file write per cycle, at most; the selected source appears on rf_* exactly one cycle after selection.
REQ-019 Load transfer occurs when ld_valid and ld_ready are both high; ld_ready = (buf_count < DEPTH), derived from registered state only.
REQ-020 Selection order per cycle: (1) forced drain, (2) core write, (3) buffer head drain, (4) load bypass.
REQ-021 Forced drain: buffer non-empty and age == AGE_MAX -> core_stall=1, buffer head drains, age clears to 0.
REQ-022 Core write: core_wb_valid and no forced drain -> core write selected, core_stall=0; any accepted load that cycle is enqueued.
REQ-023 Head drain: no forced drain, no core write, buffer non-empty -> head drains; any accepted load is enqueued behind it.
REQ-024 Bypass: buffer empty, no core write, accepted load -> load goes straight to rf_*; not enqueued.
REQ-025 Buffer is FIFO; pointers wrap modulo DEPTH; enqueue and dequeue in the same cycle leave buf_count unchanged.
REQ-026 Age counter: increments each cycle the buffer is non-empty and the head does not drain; saturates at AGE_MAX; clears when the head drains or the buffer is empty.
REQ-027 WAW squash: a selected core write with rd equal to a buffered entry's rd marks that entry squashed; a load accepted in the same cycle with ld_rd == core_wb_rd is enqueued already squashed (load is older).
REQ-028 A squashed entry still drains in normal order but produces rf_we=0.
REQ-029 rd == 0: the request is consumed normally but rf_we=0 for it; x0 is never written.
REQ-030 When rf_we=0, rf_waddr and rf_wdata hold their previous values.
REQ-031 core_stall is high only in a forced-drain cycle; a stalled core request is not consumed and must be re-presented.

Reset
REQ-032 rst_n low asynchronously clears: rf_we=0, rf_waddr=0, rf_wdata=0, buf_count=0, age=0, all squash flags=0, pointers=0.
REQ-033 During reset: ld_ready=0, core_stall=0.
REQ-034 Reset mid-operation discards buffered entries without writing them; first selection possible on the first rising edge after rst_n rises.

Verification
REQ-035 Idle buffer, ld_valid with ld_rd=5, ld_data=0xAAAA_0001, no core write -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xAAAA_0001; buf_count stays 0.
REQ-036 core_wb_valid held high for 8 cycles, one load (rd=7) accepted in cycle 0 -> core writes cycles 1-4, core_stall=1 in cycle 4, rd=7 written in cycle 5, core resumes.
REQ-037 Buffer full (DEPTH=2) with continuous core writes -> ld_ready=0; a third load is not accepted until a drain occurs.
REQ-038 Load rd=9 buffered, then core write rd=9 data 0x1234 -> rf_waddr=9 data 0x1234 written; later drain of the load gives rf_we=0; x9 final value 0x1234.
REQ-039 Core write rd=0 and load rd=0 -> both consumed, rf_we never asserted.
REQ-040 rst_n pulsed low with buf_count=2 -> outputs zero immediately, buf_count=0, no buffered write occurs after release.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: merges single-cycle core writes and long-latency load
// results onto one registered register-file write port, with a small load buffer.
module wb_port_arbiter #(
  parameter int N       = 32,
  parameter int DEPTH   = 2,
  parameter int AGE_MAX = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       core_wb_valid,
  input  logic [4:0]                 core_wb_rd,
  input  logic [N-1:0]               core_wb_data,
  output logic                       core_stall,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [4:0]                 ld_rd,
  input  logic [N-1:0]               ld_data,
  output logic                       rf_we,
  output logic [4:0]                 rf_waddr,
  output logic [N-1:0]               rf_wdata,
  output logic [$clog2(DEPTH+1)-1:0] buf_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AW = $clog2(AGE_MAX + 1);

  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_C = PW'(DEPTH - 1);
  localparam logic [AW-1:0] AGE_C  = AW'(AGE_MAX);

  // Buffer storage; sq_q marks entries overwritten by a younger core write.
  logic [4:0]       rd_q   [DEPTH];
  logic [N-1:0]     data_q [DEPTH];
  logic [DEPTH-1:0] sq_q;
  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [CW-1:0]    count_q;
  logic [AW-1:0]    age_q;

  logic             empty;
  logic             ld_acc;
  logic             force_drain;
  logic             core_sel;
  logic             drain;
  logic             bypass;
  logic             enq;
  logic             enq_sq;
  logic             sel_we;
  logic [4:0]       sel_addr;
  logic [N-1:0]     sel_data;
  logic [CW-1:0]    count_d;
  logic [AW-1:0]    age_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + PW'(1);
  endfunction

  // Load handshake: a result transfers on a cycle where ld_valid && ld_ready.
  // ld_ready depends only on the registered occupancy, never on ld_valid.
  always_comb begin
    empty       = (count_q == '0);
    ld_ready    = rst_n && (count_q < FULL_C);
    ld_acc      = ld_valid && ld_ready;
    force_drain = rst_n && !empty && (age_q == AGE_C);
    core_sel    = rst_n && core_wb_valid && !force_drain;
    drain       = rst_n && !empty && !core_sel;
    bypass      = rst_n && empty && !core_wb_valid && ld_acc;
    enq         = ld_acc && !bypass;
    // A load accepted alongside a same-rd core write is older, so it is dead.
    enq_sq      = core_sel && (ld_rd == core_wb_rd);
  end

  assign core_stall = force_drain;
  assign buf_count  = count_q;

  always_comb begin
    sel_we   = 1'b0;
    sel_addr = core_wb_rd;
    sel_data = core_wb_data;
    if (drain) begin
      sel_we   = !sq_q[head_q] && (rd_q[head_q] != 5'd0);
      sel_addr = rd_q[head_q];
      sel_data = data_q[head_q];
    end else if (core_sel) begin
      sel_we   = (core_wb_rd != 5'd0);
      sel_addr = core_wb_rd;
      sel_data = core_wb_data;
    end else if (bypass) begin
      sel_we   = (ld_rd != 5'd0);
      sel_addr = ld_rd;
      sel_data = ld_data;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({enq, drain})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Age counts the cycles the head has been waiting, including its enqueue cycle.
  always_comb begin
    age_d = age_q;
    if (drain || (empty && !enq)) begin
      age_d = '0;
    end else if (age_q != AGE_C) begin
      age_d = age_q + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= sel_we;
      if (sel_we) begin
        rf_waddr <= sel_addr;
        rf_wdata <= sel_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      age_q   <= '0;
      sq_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      age_q   <= age_d;
      if (drain) begin
        head_q <= ptr_inc(head_q);
      end
      // Stale free slots may also match; the enqueue below rewrites their flag.
      if (core_sel) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (rd_q[i] == core_wb_rd) begin
            sq_q[i] <= 1'b1;
          end
        end
      end
      if (enq) begin
        tail_q         <= ptr_inc(tail_q);
        rd_q[tail_q]   <= ld_rd;
        data_q[tail_q] <= ld_data;
        sq_q[tail_q]   <= enq_sq;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: register-file writes are checked in order
// against an expected queue; occupancy, stall and ready are checked per step.
module tb_wb_port_arbiter;

  localparam int N = 32;
  localparam int W = 5 + N;

  logic         clk;
  logic         rst_n;
  logic         core_wb_valid;
  logic [4:0]   core_wb_rd;
  logic [N-1:0] core_wb_data;
  logic         core_stall;
  logic         ld_valid;
  logic         ld_ready;
  logic [4:0]   ld_rd;
  logic [N-1:0] ld_data;
  logic         rf_we;
  logic [4:0]   rf_waddr;
  logic [N-1:0] rf_wdata;
  logic [1:0]   buf_count;

  logic [W-1:0] exp_q[$];
  logic [N-1:0] shadow [32];
  int           n_vec;
  int           n_err;

  wb_port_arbiter #(.N(N), .DEPTH(2), .AGE_MAX(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .core_wb_valid (core_wb_valid),
    .core_wb_rd    (core_wb_rd),
    .core_wb_data  (core_wb_data),
    .core_stall    (core_stall),
    .ld_valid      (ld_valid),
    .ld_ready      (ld_ready),
    .ld_rd         (ld_rd),
    .ld_data       (ld_data),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .buf_count     (buf_count)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cv, input logic [4:0] crd, input logic [N-1:0] cd,
                       input logic lv, input logic [4:0] lrd, input logic [N-1:0] ldd);
    core_wb_valid = cv;
    core_wb_rd    = crd;
    core_wb_data  = cd;
    ld_valid      = lv;
    ld_rd         = lrd;
    ld_data       = ldd;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
  endtask

  task automatic push(input logic [4:0] rd, input logic [N-1:0] data);
    exp_q.push_back({rd, data});
  endtask

  // Scoreboard: every observed write must be the next expected one.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n && rf_we) begin
      if (exp_q.size() == 0) begin
        check("spurious_we", 64'(rf_we), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("wb_order", 64'({rf_waddr, rf_wdata}), 64'(e));
      end
      shadow[rf_waddr] = rf_wdata;
    end
  end

  initial begin
    int k;
    logic [4:0]   r_rd;
    logic [N-1:0] r_data;
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 32; i++) shadow[i] = '0;

    // Reset with requests asserted: ready and stall must stay low
    rst_n = 1'b1;
    drive(1'b1, 5'd3, 32'h1111_1111, 1'b1, 5'd4, 32'h2222_2222);
    #1 rst_n = 1'b0;
    #2;
    check("rst_rf_we", 64'(rf_we), 64'(0));
    check("rst_rf_waddr", 64'(rf_waddr), 64'(0));
    check("rst_rf_wdata", 64'(rf_wdata), 64'(0));
    check("rst_buf_count", 64'(buf_count), 64'(0));
    check("rst_ld_ready", 64'(ld_ready), 64'(0));
    check("rst_core_stall", 64'(core_stall), 64'(0));
    @(posedge clk);
    @(posedge clk);
    #2;
    idle();
    rst_n = 1'b1;
    tick();
    check("post_rst_we", 64'(rf_we), 64'(0));

    // Idle buffer: load bypasses straight to the write port
    drive(1'b0, 5'd0, '0, 1'b1, 5'd5, 32'hAAAA_0001);
    #1;
    check("byp_ready", 64'(ld_ready), 64'(1));
    push(5'd5, 32'hAAAA_0001);
    tick();
    idle();
    check("byp_we", 64'(rf_we), 64'(1));
    check("byp_waddr", 64'(rf_waddr), 64'(5));
    check("byp_wdata", 64'(rf_wdata), 64'(32'hAAAA_0001));
    check("byp_count", 64'(buf_count), 64'(0));
    tick();
    check("hold_we", 64'(rf_we), 64'(0));
    check("hold_waddr", 64'(rf_waddr), 64'(5));
    check("hold_wdata", 64'(rf_wdata), 64'(32'hAAAA_0001));

    // Continuous core writes with one load: forced drain after AGE_MAX cycles
    k = 0;
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, 5'(10 + k), 32'hC000_0000 + 32'(k), c == 0, 5'd7, 32'h7777_0007);
      #1;
      check("age_stall", 64'(core_stall), 64'(c == 4));
      check("age_count", 64'(buf_count), 64'((c >= 1 && c <= 4) ? 1 : 0));
      if (c == 4) begin
        push(5'd7, 32'h7777_0007);
      end else begin
        push(5'(10 + k), 32'hC000_0000 + 32'(k));
        k++;
      end
      tick();
    end
    idle();
    tick();

    // Buffer full: third load waits until a drain frees a slot
    drive(1'b1, 5'd20, 32'hC20_0000, 1'b1, 5'd21, 32'hD21);
    #1;
    check("full_ready0", 64'(ld_ready), 64'(1));
    push(5'd20, 32'hC20_0000);
    tick();
    drive(1'b1, 5'd20, 32'hC20_0001, 1'b1, 5'd22, 32'hD22);
    #1;
    check("full_count1", 64'(buf_count), 64'(1));
    push(5'd20, 32'hC20_0001);
    tick();
    for (int c = 2; c < 4; c++) begin
      drive(1'b1, 5'd20, 32'hC20_0000 + 32'(c), 1'b1, 5'd23, 32'hD23);
      #1;
      check("full_ready", 64'(ld_ready), 64'(0));
      check("full_count2", 64'(buf_count), 64'(2));
      check("full_nostall", 64'(core_stall), 64'(0));
      push(5'd20, 32'hC20_0000 + 32'(c));
      tick();
    end
    drive(1'b1, 5'd20, 32'hC20_0004, 1'b1, 5'd23, 32'hD23);
    #1;
    check("full_stall", 64'(core_stall), 64'(1));
    check("full_ready_st", 64'(ld_ready), 64'(0));
    push(5'd21, 32'hD21);
    tick();
    drive(1'b0, 5'd0, '0, 1'b1, 5'd23, 32'hD23);
    #1;
    check("full_ready_again", 64'(ld_ready), 64'(1));
    push(5'd22, 32'hD22);
    tick();
    idle();
    #1;
    check("full_count_tail", 64'(buf_count), 64'(1));
    push(5'd23, 32'hD23);
    tick();
    check("full_last_addr", 64'(rf_waddr), 64'(23));
    check("full_empty", 64'(buf_count), 64'(0));

    // WAW squash of a buffered load by a younger core write
    drive(1'b1, 5'd3, 32'h3333, 1'b1, 5'd9, 32'h9999);
    push(5'd3, 32'h3333);
    tick();
    drive(1'b1, 5'd9, 32'h1234, 1'b0, 5'd0, '0);
    push(5'd9, 32'h1234);
    tick();
    check("waw_core_addr", 64'(rf_waddr), 64'(9));
    check("waw_core_data", 64'(rf_wdata), 64'(32'h1234));
    idle();
    tick();
    check("waw_drain_we", 64'(rf_we), 64'(0));
    check("waw_hold_data", 64'(rf_wdata), 64'(32'h1234));
    check("waw_count", 64'(buf_count), 64'(0));
    @(negedge clk);
    check("waw_x9", 64'(shadow[9]), 64'(32'h1234));
    tick();

    // Same-cycle squash: load enqueued already dead
    drive(1'b1, 5'd11, 32'hB0, 1'b1, 5'd11, 32'hB1);
    push(5'd11, 32'hB0);
    tick();
    idle();
    check("same_core_we", 64'(rf_we), 64'(1));
    tick();
    check("same_drain_we", 64'(rf_we), 64'(0));
    check("same_count", 64'(buf_count), 64'(0));
    @(negedge clk);
    check("same_x11", 64'(shadow[11]), 64'(32'hB0));
    tick();

    // x0 is never written, from either source or via bypass
    drive(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
    tick();
    idle();
    check("x0_core_we", 64'(rf_we), 64'(0));
    check("x0_count", 64'(buf_count), 64'(1));
    tick();
    check("x0_drain_we", 64'(rf_we), 64'(0));
    drive(1'b0, 5'd0, '0, 1'b1, 5'd0, 32'hBEEF);
    tick();
    idle();
    check("x0_byp_we", 64'(rf_we), 64'(0));
    check("x0_hold_addr", 64'(rf_waddr), 64'(11));
    tick();

    // Reset with a full buffer discards the entries
    drive(1'b1, 5'd12, 32'hC12_0000, 1'b1, 5'd24, 32'hD24);
    push(5'd12, 32'hC12_0000);
    tick();
    drive(1'b1, 5'd12, 32'hC12_0001, 1'b1, 5'd25, 32'hD25);
    push(5'd12, 32'hC12_0001);
    tick();
    idle();
    check("rst2_count_pre", 64'(buf_count), 64'(2));
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst2_we", 64'(rf_we), 64'(0));
    check("rst2_waddr", 64'(rf_waddr), 64'(0));
    check("rst2_wdata", 64'(rf_wdata), 64'(0));
    check("rst2_count", 64'(buf_count), 64'(0));
    @(posedge clk);
    #2 rst_n = 1'b1;
    drive(1'b0, 5'd0, '0, 1'b1, 5'd30, 32'h3030);
    push(5'd30, 32'h3030);
    tick();
    idle();
    check("rst2_first_we", 64'(rf_we), 64'(1));
    check("rst2_first_addr", 64'(rf_waddr), 64'(30));
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst2_no_drain", 64'(rf_we), 64'(0));
    end

    // Random bypass stream
    for (int c = 0; c < 6; c++) begin
      r_rd   = 5'($urandom_range(1, 31));
      r_data = $urandom;
      drive(1'b0, 5'd0, '0, 1'b1, r_rd, r_data);
      push(r_rd, r_data);
      tick();
      check("rnd_addr", 64'(rf_waddr), 64'(r_rd));
      check("rnd_data", 64'(rf_wdata), 64'(r_data));
    end
    idle();
    repeat (3) tick();
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
